// File: rtl/pixel_out_pkg.sv
// rtl/pixel_out_pkg.sv - shared types, FIFO entry layout and clog2 helper for pixel_output_streamer
package pixel_out_pkg;

  typedef enum logic {
    SEND = 1'b0,
    GAP  = 1'b1
  } state_t;

  // FIFO entry is {frame_start, line_end, data[DATA_W-1:0]}
  localparam int DATA_LSB = 0;

  function automatic int flag_le_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int flag_fs_bit(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy counter
module sync_fifo
  import pixel_out_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pixel_output_streamer.sv
// rtl/pixel_output_streamer.sv - buffered pixel output stage with line gap and frame counting
// Optional frame_checksum output enabled by defining OUT_CHECKSUM_EN.
module pixel_output_streamer
  import pixel_out_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int LINE_GAP    = 2,
  parameter int FRAME_LINES = 512
) (
  input  logic              Clk_in,
  input  logic              Rst_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_frame_start,
  input  logic              in_line_end,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              Clk_out,
  output logic              Start_out,
  output logic              H_Valid_out,
  output logic              H_Jump_out,
  output logic [DATA_W-1:0] R_Bmp_Data,
  output logic [15:0]       line_count,
  output logic              frame_done
`ifdef OUT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] frame_checksum
`endif
);

  localparam int ENTRY_W = DATA_W + 2;
  localparam int FS_BIT  = flag_fs_bit(DATA_W);
  localparam int LE_BIT  = flag_le_bit(DATA_W);
  localparam int GAP_W   = clog2(LINE_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);

  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head_fs;
  logic               head_le;
  logic [15:0]        base_count;
  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;

  assign Clk_out    = Clk_in;
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == SEND) && !empty && out_ready;
  assign wdata      = {in_frame_start, in_line_end, in_data};
  assign head_fs    = rdata[FS_BIT];
  assign head_le    = rdata[LE_BIT];
  // Frame start clears before the line end increments, so a single-pixel line counts as 1.
  assign base_count = head_fs ? 16'd0 : line_count;

  sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (Clk_in),
    .rst  (Rst_in),
    .push (push),
    .pop  (pop),
    .wdata(wdata),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state       <= SEND;
      gap_cnt     <= '0;
      Start_out   <= 1'b0;
      H_Valid_out <= 1'b0;
      H_Jump_out  <= 1'b0;
      R_Bmp_Data  <= '0;
      line_count  <= '0;
      frame_done  <= 1'b0;
`ifdef OUT_CHECKSUM_EN
      frame_checksum <= '0;
`endif
    end else begin
      H_Valid_out <= pop;
      Start_out   <= pop && head_fs;
      H_Jump_out  <= pop && head_le;
      frame_done  <= 1'b0;

      if (pop) begin
        R_Bmp_Data <= rdata[DATA_W-1:DATA_LSB];
`ifdef OUT_CHECKSUM_EN
        frame_checksum <= head_fs ? rdata[DATA_W-1:DATA_LSB]
                                  : (frame_checksum ^ rdata[DATA_W-1:DATA_LSB]);
`endif
        if (head_le) begin
          if (base_count == LAST_LINE) begin
            line_count <= '0;
            frame_done <= 1'b1;
          end else begin
            line_count <= base_count + 16'd1;
          end
        end else begin
          line_count <= base_count;
        end
      end

      case (state)
        SEND: begin
          if (pop && head_le && (LINE_GAP > 0)) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= SEND;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= SEND;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_output_streamer.sv
// tb/tb_pixel_output_streamer.sv - directed self-checking bench for pixel_output_streamer
module tb_pixel_output_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_frame_start;
  logic        in_line_end;
  logic [23:0] in_data;
  logic        out_ready;
  logic        clk_out;
  logic        start_out;
  logic        h_valid;
  logic        h_jump;
  logic [23:0] bmp_data;
  logic [15:0] line_count;
  logic        frame_done;
`ifdef OUT_CHECKSUM_EN
  logic [23:0] frame_checksum;
`endif

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  pixel_output_streamer #(
    .DATA_W(24),
    .FIFO_DEPTH(16),
    .LINE_GAP(2),
    .FRAME_LINES(2)
  ) dut (
    .Clk_in        (clk),
    .Rst_in        (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_frame_start(in_frame_start),
    .in_line_end   (in_line_end),
    .in_data       (in_data),
    .out_ready     (out_ready),
    .Clk_out       (clk_out),
    .Start_out     (start_out),
    .H_Valid_out   (h_valid),
    .H_Jump_out    (h_jump),
    .R_Bmp_Data    (bmp_data),
    .line_count    (line_count),
    .frame_done    (frame_done)
`ifdef OUT_CHECKSUM_EN
    ,
    .frame_checksum(frame_checksum)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fs, input logic le, input logic [23:0] d);
    in_valid       = v;
    in_frame_start = fs;
    in_line_end    = le;
    in_data        = d;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    step();
    step();
    check("rst_hvalid", {31'd0, h_valid}, 32'd0);
    check("rst_start", {31'd0, start_out}, 32'd0);
    check("rst_jump", {31'd0, h_jump}, 32'd0);
    check("rst_data", {8'd0, bmp_data}, 32'd0);
    check("rst_lines", {16'd0, line_count}, 32'd0);
    check("rst_fdone", {31'd0, frame_done}, 32'd0);
    check("rst_inready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Line 1 of frame: 1..4, first pixel frame_start, last pixel line_end.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b1, (k == 0), (k == 3), 24'(k + 1));
      else drive(1'b0, 1'b0, 1'b0, 24'h0);
      step();
      if (k == 0) check("l1_latency", {31'd0, h_valid}, 32'd0);
      else if (k <= 4) begin
        check("l1_valid", {31'd0, h_valid}, 32'd1);
        check("l1_data", {8'd0, bmp_data}, 32'(k));
        check("l1_start", {31'd0, start_out}, (k == 1) ? 32'd1 : 32'd0);
        check("l1_jump", {31'd0, h_jump}, (k == 4) ? 32'd1 : 32'd0);
      end else begin
        check("l1_gap_valid", {31'd0, h_valid}, 32'd0);
        check("l1_gap_hold", {8'd0, bmp_data}, 32'd4);
      end
    end
    check("l1_lines", {16'd0, line_count}, 32'd1);
    check("l1_fdone", {31'd0, frame_done}, 32'd0);
    step();

    // Line 2: 5..8 closes the 2-line frame.
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, 1'b0, (k == 3), 24'(k + 5));
      else drive(1'b0, 1'b0, 1'b0, 24'h0);
      step();
      if (k >= 1 && k <= 4) begin
        check("l2_data", {8'd0, bmp_data}, 32'(k + 4));
        check("l2_fdone", {31'd0, frame_done}, (k == 4) ? 32'd1 : 32'd0);
        check("l2_jump", {31'd0, h_jump}, (k == 4) ? 32'd1 : 32'd0);
        if (k == 4) check("l2_lines_wrap", {16'd0, line_count}, 32'd0);
      end else if (k == 5) begin
        check("l2_fdone_pulse", {31'd0, frame_done}, 32'd0);
      end
    end
    step();
    step();

    // Fill all 16 entries with the sink stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("fill_inready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 24'h100 + 24'(k));
      step();
      check("fill_novalid", {31'd0, h_valid}, 32'd0);
    end
    check("full_inready", {31'd0, in_ready}, 32'd0);
    // Push attempt while full, coincident with the first pop: must be refused.
    drive(1'b1, 1'b0, 1'b0, 24'h1FF);
    out_ready = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    check("drain_first", {8'd0, bmp_data}, 32'h100);
    for (int k = 1; k < 17; k++) begin
      step();
      if (k < 16) begin
        check("drain_valid", {31'd0, h_valid}, 32'd1);
        check("drain_data", {8'd0, bmp_data}, 32'h100 + 32'(k));
      end else begin
        check("drain_end", {31'd0, h_valid}, 32'd0);
        check("drain_hold", {8'd0, bmp_data}, 32'h10F);
      end
    end

    // Alternating out_ready with a continuous 8-pixel stream.
    for (int c = 0; c < 18; c++) begin
      out_ready = (c % 2 == 0);
      if (c < 8) drive(1'b1, 1'b0, 1'b0, 24'h200 + 24'(c));
      else drive(1'b0, 1'b0, 1'b0, 24'h0);
      step();
      if (c >= 2) begin
        check("tog_valid", {31'd0, h_valid}, (c % 2 == 0) ? 32'd1 : 32'd0);
        check("tog_data", {8'd0, bmp_data}, 32'h200 + 32'((c - 2) / 2));
      end
    end
    out_ready = 1'b1;

    // Single-pixel line: frame_start and line_end together.
    drive(1'b1, 1'b1, 1'b1, 24'h0AB);
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    step();
    check("sp_data", {8'd0, bmp_data}, 32'h0AB);
    check("sp_start", {31'd0, start_out}, 32'd1);
    check("sp_jump", {31'd0, h_jump}, 32'd1);
    check("sp_lines", {16'd0, line_count}, 32'd1);
    check("sp_fdone", {31'd0, frame_done}, 32'd0);
    step();
    step();

    // Buffer 5 pixels, then reset.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 24'h300 + 24'(k));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    rst = 1'b1;
    step();
    check("mrst_valid", {31'd0, h_valid}, 32'd0);
    check("mrst_data", {8'd0, bmp_data}, 32'd0);
    check("mrst_lines", {16'd0, line_count}, 32'd0);
    check("mrst_inready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("mrst_discard", {31'd0, h_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 24'h3AA);
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    step();
    check("post_valid", {31'd0, h_valid}, 32'd1);
    check("post_data", {8'd0, bmp_data}, 32'h3AA);
    check("post_start", {31'd0, start_out}, 32'd0);
    step();
    check("post_nodup", {31'd0, h_valid}, 32'd0);

`ifdef OUT_CHECKSUM_EN
    step();
    step();
    drive(1'b1, 1'b1, 1'b1, 24'h0F0F0F);
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    step();
    check("cs_first", {8'd0, frame_checksum}, 32'h0F0F0F);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 24'h00FF00);
    step();
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    step();
    check("cs_fdone", {31'd0, frame_done}, 32'd1);
    check("cs_value", {8'd0, frame_checksum}, 32'h0FF00F);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
